// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues req/ack reads to imem, hands words to decode.
// Latency: ack in cycle N -> if_valid in N+1; steady state one instruction per 2 cycles.
// Backpressure: if_ready=0 holds the word with no new request; stall only gates new requests.
// Optional FETCH_PERF_CNT_EN adds the fetch_count handshake counter port.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drain_addr, drain_addr_nxt;
    logic        valid_q, valid_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic [31:0] ipc_q, ipc_nxt;

    // Word-aligned redirect target; the low two bits are simply masked off.
    logic [31:0] redirect_tgt;
    // Where to go once the current transaction is over: stall parks us in IDLE.
    state_t      resume_state;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign resume_state = stall ? S_IDLE : S_REQ;

    // State is register-based, so imem_req drops the moment reset asserts.
    assign imem_req  = (state == S_REQ) || (state == S_DRAIN);
    // DRAIN keeps presenting the abandoned address so the memory sees a stable request.
    assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc     = ipc_q;

    // Next-state and datapath decisions; redirect outranks everything in every state.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        valid_nxt      = valid_q;
        instr_nxt      = instr_q;
        ipc_nxt        = ipc_q;
        case (state)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_tgt;
                end
                state_nxt = resume_state;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_tgt;
                    if (imem_ack) begin
                        // Returned word belongs to the old path: drop it.
                        state_nxt = resume_state;
                    end else begin
                        // Request cannot be withdrawn; finish it at the old address.
                        drain_addr_nxt = pc;
                        state_nxt      = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    instr_nxt = imem_rdata;
                    ipc_nxt   = pc;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc + PC_STEP;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    valid_nxt = 1'b0;
                    pc_nxt    = redirect_tgt;
                    state_nxt = resume_state;
                end else if (if_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = resume_state;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_tgt;
                end
                if (imem_ack) begin
                    state_nxt = resume_state;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Architectural state and the decode-facing output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= 32'h0;
            ipc_q      <= 32'h0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
            valid_q    <= valid_nxt;
            instr_q    <= instr_nxt;
            ipc_q      <= ipc_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Counts decode handshakes, including one that coincides with a flushing redirect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count <= 32'h0;
        end else if (valid_q && if_ready) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic, scoreboard-checked.
// Inputs change on the falling edge; monitor and model sample shortly after it.
// Memory model acks after a configurable (optionally random) number of wait cycles.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    fetch_sequencer #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Instruction memory: fixed image, ack after lat_cur wait cycles.
    int lat_max  = 0;
    int lat_cur  = 0;
    int wait_cnt = 0;
    bit lat_rand = 1'b0;

    always @(negedge clock) begin
        imem_rdata = mem_word(imem_addr);
        if (!imem_req) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= lat_cur) begin
            imem_ack = 1'b1;
            wait_cnt = 0;
            lat_cur  = lat_rand ? int'($urandom_range(0, lat_max)) : lat_max;
        end else begin
            imem_ack = 1'b0;
            wait_cnt++;
        end
    end

    // Reference model: tracks the program-order address stream and which requests are stale.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;
    item_t       sb[$];
    logic [31:0] exp_pc = RST_PC;
    bit          stale = 1'b0;
    bit          prev_pending = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always @(negedge clock) begin
        #2;
        if (reset) begin
            sb.delete();
            exp_pc       = RST_PC;
            stale        = 1'b0;
            prev_pending = 1'b0;
        end else begin
            if (prev_pending) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_held", imem_addr, prev_addr);
            end
            if (imem_req && imem_ack && !redirect_valid && !stale) begin
                item_t it;
                chk("fetch_addr", imem_addr, exp_pc);
                it.pc    = exp_pc;
                it.instr = mem_word(exp_pc);
                sb.push_back(it);
                exp_pc = exp_pc + 32'd4;
            end
            if (imem_req && imem_ack) stale = 1'b0;
            if (redirect_valid) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
                if (imem_req && !imem_ack) stale = 1'b1;
                sb.delete();
            end
            prev_pending = imem_req && !imem_ack;
            prev_addr    = imem_addr;
        end
    end

    // Monitor: compares every decode handshake against the scoreboard.
    int          cyc = 0;
    bit          tput_chk = 1'b0;
    bit          have_last = 1'b0;
    int          last_hs = 0;
    int          hs_total = 0;
    bit          hold_prev = 1'b0;
    logic [31:0] hold_pc = 32'h0;
    logic [31:0] hold_instr = 32'h0;

    always @(negedge clock) begin
        #1;
        cyc++;
        if (reset) begin
            hold_prev = 1'b0;
            have_last = 1'b0;
            hs_total  = 0;
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_count_reset", fetch_count, 32'h0);
`endif
        end else begin
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_count", fetch_count, 32'(hs_total));
`endif
            chk("valid_vs_model", 32'(if_valid), 32'(sb.size() != 0));
            if (if_valid) chk("no_req_while_holding", 32'(imem_req), 32'd0);
            if (hold_prev) begin
                chk("hold_valid", 32'(if_valid), 32'd1);
                chk("hold_pc", if_pc, hold_pc);
                chk("hold_instr", if_instr, hold_instr);
            end
            if (if_valid && if_ready) begin
                hs_total++;
                chk("sb_has_item", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    item_t it;
                    it = sb.pop_front();
                    chk("if_pc", if_pc, it.pc);
                    chk("if_instr", if_instr, it.instr);
                end
                if (tput_chk) begin
                    if (have_last) chk("throughput", 32'(cyc - last_hs), 32'd2);
                    have_last = 1'b1;
                    last_hs   = cyc;
                end
            end
            hold_prev  = if_valid && !if_ready && !redirect_valid;
            hold_pc    = if_pc;
            hold_instr = if_instr;
        end
    end

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Directed scenarios followed by random traffic.
    initial begin
        bit ok;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);

        // Zero-wait streaming: 0,4,8,12 at one per two cycles.
        @(negedge clock);
        reset    = 1'b0;
        tput_chk = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (if_valid && if_ready && if_pc == 32'd12) begin ok = 1'b1; break; end
        end
        chk("wait_pc12", 32'(ok), 32'd1);
        @(negedge clock);
        tput_chk = 1'b0;

        // Decode backpressure at pc 8.
        pulse_reset();
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (if_valid && if_pc == 32'd8) begin ok = 1'b1; break; end
        end
        chk("wait_pc8", 32'(ok), 32'd1);
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_valid", 32'(if_valid), 32'd1);
            chk("bp_pc", if_pc, 32'd8);
            chk("bp_no_req", 32'(imem_req), 32'd0);
        end
        if_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (imem_req) begin ok = 1'b1; break; end
        end
        chk("wait_req_after_bp", 32'(ok), 32'd1);
        chk("addr_after_bp", imem_addr, 32'd12);

        // Redirect while a slow request to 0x10 is in flight.
        @(negedge clock);
        reset = 1'b1;
        lat_max = 3; lat_cur = 3; lat_rand = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (imem_req && imem_addr == 32'h10) begin ok = 1'b1; break; end
        end
        chk("wait_req_0x10", 32'(ok), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clock);
        redirect_valid = 1'b0;
        lat_max = 0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("drain_addr", imem_addr, 32'h10);
            if (imem_ack) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        chk("wait_drain_ack", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (imem_req) begin ok = 1'b1; break; end
        end
        chk("wait_req_0x100", 32'(ok), 32'd1);
        chk("addr_after_redirect", imem_addr, 32'h100);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (if_valid) begin ok = 1'b1; break; end
        end
        chk("wait_valid_0x100", 32'(ok), 32'd1);
        chk("pc_after_redirect", if_pc, 32'h100);
        chk("instr_after_redirect", if_instr, mem_word(32'h100));

        // Unaligned redirect while holding a word.
        lat_cur  = 0;
        if_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        chk("wait_hold", 32'(ok), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(negedge clock);
        redirect_valid = 1'b0;
        chk("flush_valid", 32'(if_valid), 32'd0);
        chk("flush_req", 32'(imem_req), 32'd1);
        chk("flush_addr", imem_addr, 32'h100);
        if_ready = 1'b1;

        // Address wrap at the top of the space.
        @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clock);
        redirect_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        chk("wait_top", 32'(ok), 32'd1);
        chk("pc_top", if_pc, 32'hFFFF_FFFC);
        @(negedge clock);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        chk("wait_wrap", 32'(ok), 32'd1);
        chk("pc_wrap", if_pc, 32'h0);

        // Stall parks the sequencer with no request.
        stall = 1'b1;
        repeat (6) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall_no_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;

        // Reset in the middle of a request.
        lat_max = 3; lat_cur = 3;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (imem_req) begin ok = 1'b1; break; end
        end
        chk("wait_req_mid", 32'(ok), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_valid", 32'(if_valid), 32'd0);
        lat_max = 0; lat_cur = 0;
        @(negedge clock);
        reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (imem_req) begin ok = 1'b1; break; end
        end
        chk("wait_req_post_rst", 32'(ok), 32'd1);
        chk("addr_post_rst", imem_addr, RST_PC);

        // Random traffic.
        lat_rand = 1'b1;
        lat_max  = 3;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if_ready       = ($urandom_range(0, 99) < 70);
            stall          = ($urandom_range(0, 99) < 20);
            redirect_valid = ($urandom_range(0, 99) < 5);
            case ($urandom_range(0, 2))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                default: redirect_pc = $urandom & 32'h3FF;
            endcase
        end
        @(negedge clock);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        if_ready       = 1'b1;
        repeat (10) @(negedge clock);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
